// File: rtl/mmio_dmem_pkg.sv
// Purpose: shared region type and address-region decode for mmio_dmem.
// Latency: combinational helper only.
// Backpressure: not applicable.
`include "mmio_defs.vh"

package mmio_dmem_pkg;

   typedef enum logic [2:0] {
      RGN_ZERO,
      RGN_CHAN,
      RGN_STATUS,
      RGN_OUT,
      RGN_RAM,
      RGN_NONE
   } mmio_rgn_t;

   // Classify a word address into one of the map regions
   function automatic mmio_rgn_t mmio_decode(input int unsigned a,
                                             input int unsigned nch,
                                             input int unsigned nout,
                                             input int unsigned ram_base,
                                             input int unsigned ram_depth);
      if (a == `MMIO_ADDR_ZERO)                            return RGN_ZERO;
      if (`MMIO_IN_RANGE(a, `MMIO_ADDR_CH0, nch))          return RGN_CHAN;
      if (a == `MMIO_ADDR_STATUS)                          return RGN_STATUS;
      if (`MMIO_IN_RANGE(a, `MMIO_ADDR_OUT0, nout))        return RGN_OUT;
      if (`MMIO_IN_RANGE(a, ram_base, ram_depth))          return RGN_RAM;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/mmio_defs.vh
// Shared address map constants and decode helpers for the mmio_dmem block.
// Address constants are plain unsized integers so they compare cleanly against 32-bit decode values.
// Guarded so that it can be pulled in by the package and by every design file.
`ifndef MMIO_DEFS_VH
`define MMIO_DEFS_VH

`define MMIO_ADDR_ZERO      0
`define MMIO_ADDR_CH0       1
`define MMIO_ADDR_STATUS    15
`define MMIO_ADDR_OUT0      16
`define MMIO_STATUS_OVR_LSB 16

// True when address a falls inside the window [lo, lo+n)
`define MMIO_IN_RANGE(a, lo, n) (((a) >= (lo)) && ((a) < ((lo) + (n))))

`endif

// File: rtl/mmio_scratch_ram.sv
// Purpose: synchronous single-port scratch RAM, read-before-write on a shared address.
// Latency: 1 cycle read; rdata only changes on a read cycle, otherwise it holds.
// Backpressure: none, every access completes in one cycle.
module mmio_scratch_ram #(
   parameter int WID   = 32,
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clock,
   input  logic           rd,
   input  logic           wr,
   input  logic [AW-1:0]  addr,
   input  logic [WID-1:0] wdata,
   output logic [WID-1:0] rdata
);

   logic [WID-1:0] mem [DEPTH];

   // Array write and registered read; NBA ordering returns the pre-write word on a shared access
   always_ff @(posedge clock) begin
      if (wr) mem[addr] <= wdata;
      if (rd) rdata <= mem[addr];
   end

endmodule

// File: rtl/mmio_dmem.sv
// Purpose: MMIO data memory: latched input channels, STATUS, output regs, scratch RAM (optional MMIO_OVERRUN_EN adds sticky overrun flags).
// Latency: reads return on q one cycle after rden; writes and captures take effect at the edge.
// Backpressure: none, every access and strobe is accepted every cycle.
`include "mmio_defs.vh"

module mmio_dmem
   import mmio_dmem_pkg::*;
#(
   parameter int WID       = 32,
   parameter int ADDR_W    = 12,
   parameter int NCH       = 5,
   parameter int NOUT      = 4,
   parameter int RAM_DEPTH = 64,
   parameter int RAM_BASE  = 64
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   address,
   input  logic [WID-1:0]      data,
   input  logic                wren,
   input  logic                rden,
   output logic [WID-1:0]      q,
   input  logic [NCH*WID-1:0]  in_value,
   input  logic [NCH-1:0]      in_strobe,
   output logic [NCH-1:0]      in_valid,
`ifdef MMIO_OVERRUN_EN
   output logic [NCH-1:0]      overrun,
`endif
   output logic [NOUT*WID-1:0] out_regs
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

   logic [31:0]     a_u;
   mmio_rgn_t       rgn;
   logic [NCH-1:0]  rd_clr;
   logic [WID-1:0]  snap [NCH];
   logic [WID-1:0]  status;
   logic [WID-1:0]  rd_word;
   logic [WID-1:0]  q_hold;
   logic            q_ram;
   logic [WID-1:0]  ram_q;

   assign a_u = 32'(address);
   assign rgn = mmio_decode(a_u, NCH, NOUT, RAM_BASE, RAM_DEPTH);

   // Per-channel read-clear: only a real read (rden) of the channel address clears its flag
   always_comb begin
      rd_clr = '0;
      for (int i = 0; i < NCH; i++)
         rd_clr[i] = rden && (a_u == 32'(`MMIO_ADDR_CH0 + i));
   end

   // STATUS word: valid flags low, overrun flags from bit 16 when enabled, zero elsewhere
   always_comb begin
      status = '0;
      status[NCH-1:0] = in_valid;
`ifdef MMIO_OVERRUN_EN
      for (int i = 0; i < NCH; i++)
         status[`MMIO_STATUS_OVR_LSB + i] = overrun[i];
`endif
   end

   // Read mux for everything except RAM, which has its own output register
   always_comb begin
      rd_word = '0;
      case (rgn)
         RGN_STATUS: rd_word = status;
         RGN_CHAN: begin
            for (int i = 0; i < NCH; i++)
               if (a_u == 32'(`MMIO_ADDR_CH0 + i)) rd_word = snap[i];
         end
         RGN_OUT: begin
            for (int j = 0; j < NOUT; j++)
               if (a_u == 32'(`MMIO_ADDR_OUT0 + j)) rd_word = out_regs[j*WID +: WID];
         end
         default: rd_word = '0;
      endcase
   end

   // Channel capture and valid flags; a strobe beats a same-edge read-clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_valid <= '0;
         for (int i = 0; i < NCH; i++) snap[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (in_strobe[i]) begin
               snap[i]     <= in_value[i*WID +: WID];
               in_valid[i] <= 1'b1;
            end else if (rd_clr[i]) begin
               in_valid[i] <= 1'b0;
            end
         end
      end
   end

`ifdef MMIO_OVERRUN_EN
   logic [NCH-1:0] ovr_set;
   logic [NCH-1:0] ovr_clr;

   // Overrun set when fresh data lands on unread data; W1C via STATUS write
   always_comb begin
      ovr_set = in_strobe & in_valid & ~rd_clr;
      ovr_clr = '0;
      for (int i = 0; i < NCH; i++)
         ovr_clr[i] = wren && (rgn == RGN_STATUS) && data[`MMIO_STATUS_OVR_LSB + i];
   end

   // Sticky overrun flags; a set on the same edge as a clear wins
   always_ff @(posedge clock or posedge reset) begin
      if (reset) overrun <= '0;
      else       overrun <= (overrun & ~ovr_clr) | ovr_set;
   end
`endif

   // Writable output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_regs <= '0;
      end else if (wren && (rgn == RGN_OUT)) begin
         for (int j = 0; j < NOUT; j++)
            if (a_u == 32'(`MMIO_ADDR_OUT0 + j)) out_regs[j*WID +: WID] <= data;
      end
   end

   mmio_scratch_ram #(
      .WID   (WID),
      .DEPTH (RAM_DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clock (clock),
      .rd    (rden && (rgn == RGN_RAM)),
      .wr    (wren && (rgn == RGN_RAM)),
      .addr  (address[RAM_AW-1:0]),
      .wdata (data),
      .rdata (ram_q)
   );

   // Read data register plus RAM-source select; both hold when rden is low
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_hold <= '0;
         q_ram  <= 1'b0;
      end else if (rden) begin
         q_hold <= rd_word;
         q_ram  <= (rgn == RGN_RAM);
      end
   end

   assign q = q_ram ? ram_q : q_hold;

endmodule

// File: tb/tb_mmio_dmem.sv
// Bench for mmio_dmem: directed map scenarios followed by randomized traffic,
// all compared against a behavioural model of the memory map kept in this file.
// Build with MMIO_OVERRUN_EN defined to cover the overrun flags as well.
module tb_mmio_dmem;

`ifdef MMIO_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic [11:0]   address;
   logic [31:0]   data;
   logic          wren, rden;
   logic [31:0]   q;
   logic [159:0]  in_value;
   logic [4:0]    in_strobe;
   logic [4:0]    in_valid;
   logic [127:0]  out_regs;
`ifdef MMIO_OVERRUN_EN
   logic [4:0]    overrun;
`endif

   mmio_dmem dut (
      .clock     (clock),
      .reset     (reset),
      .address   (address),
      .data      (data),
      .wren      (wren),
      .rden      (rden),
      .q         (q),
      .in_value  (in_value),
      .in_strobe (in_strobe),
      .in_valid  (in_valid),
`ifdef MMIO_OVERRUN_EN
      .overrun   (overrun),
`endif
      .out_regs  (out_regs)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0]  m_snap [5];
   logic [4:0]   m_valid, m_ovr;
   logic [127:0] m_out;
   logic [31:0]  m_ram [64];
   bit           m_ram_ok [64];
   logic [31:0]  m_q;
   bit           m_q_ok;

   function automatic logic [31:0] m_read(input int a, output bit ok);
      ok = 1'b1;
      if (a >= 1 && a <= 5) return m_snap[a-1];
      if (a == 15) return {11'd0, (OVR_EN ? m_ovr : 5'd0), 11'd0, m_valid};
      if (a >= 16 && a <= 19) return m_out[(a-16)*32 +: 32];
      if (a >= 64 && a <= 127) begin
         ok = m_ram_ok[a-64];
         return m_ram[a-64];
      end
      return 32'd0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 5; i++) m_snap[i] = '0;
      m_valid = '0; m_ovr = '0; m_out = '0; m_q = '0; m_q_ok = 1'b1;
   endtask

   // One clock edge of the memory map, from the pre-edge state
   task automatic m_edge(input int a, input logic [31:0] d, input logic we, input logic re,
                         input logic [4:0] stb, input logic [159:0] vals);
      logic [4:0] nv, no;
      bit ok;
      logic [31:0] r;
      if (re) begin
         r = m_read(a, ok);
         m_q = r; m_q_ok = ok;
      end
      nv = m_valid;
      no = m_ovr;
      if (OVR_EN && we && a == 15) no = no & ~d[20:16];
      for (int i = 0; i < 5; i++) begin
         if (stb[i]) begin
            if (m_valid[i] && !(re && a == i+1)) no[i] = 1'b1;
            m_snap[i] = vals[i*32 +: 32];
            nv[i] = 1'b1;
         end else if (re && a == i+1) begin
            nv[i] = 1'b0;
         end
      end
      if (we && a >= 16 && a <= 19) m_out[(a-16)*32 +: 32] = d;
      if (we && a >= 64 && a <= 127) begin
         m_ram[a-64] = d;
         m_ram_ok[a-64] = 1'b1;
      end
      m_valid = nv;
      m_ovr = OVR_EN ? no : 5'd0;
   endtask

   task automatic check_all();
      if (m_q_ok) chk("q", 128'(q), 128'(m_q));
      chk("in_valid", 128'(in_valid), 128'(m_valid));
      chk("out_regs", out_regs, m_out);
`ifdef MMIO_OVERRUN_EN
      chk("overrun", 128'(overrun), 128'(m_ovr));
`endif
   endtask

   // Drive one access at the negedge, run the edge, idle the bus, check at the next negedge
   task automatic step(input int a, input logic [31:0] d, input logic we, input logic re,
                       input logic [4:0] stb);
      address = a[11:0]; data = d; wren = we; rden = re; in_strobe = stb;
      m_edge(a, d, we, re, stb, in_value);
      @(posedge clock);
      #1;
      wren = 1'b0; rden = 1'b0; in_strobe = '0;
      @(negedge clock);
      check_all();
   endtask

   int ch_sel, a_r;
   logic [4:0] stb_r;

   initial begin
      for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;
      m_reset();
      reset = 1'b1; address = '0; data = '0; wren = 1'b0; rden = 1'b0;
      in_value = '0; in_strobe = '0;
      @(negedge clock);
      chk("rst_q", 128'(q), 128'd0);
      chk("rst_valid", 128'(in_valid), 128'd0);
      chk("rst_out", out_regs, 128'd0);
      reset = 1'b0;

      // 1: zero / status / out / unmapped reads after reset
      step(0, 0, 0, 1, 0);   chk("t1_a0", 128'(q), 128'd0);
      step(15, 0, 0, 1, 0);  chk("t1_a15", 128'(q), 128'd0);
      step(16, 0, 0, 1, 0);  chk("t1_a16", 128'(q), 128'd0);
      step(999, 0, 0, 1, 0); chk("t1_a999", 128'(q), 128'd0);

      // 2: channel 2 capture, STATUS, read-clear
      in_value[2*32 +: 32] = 32'hDEAD_BEEF;
      step(0, 0, 0, 0, 5'b00100);
      chk("t2_valid", 128'(in_valid), 128'(5'b00100));
      step(15, 0, 0, 1, 0);  chk("t2_status", 128'(q), 128'h4);
      step(3, 0, 0, 1, 0);   chk("t2_ch2", 128'(q), 128'hDEAD_BEEF);
      chk("t2_cleared", 128'(in_valid), 128'd0);

      // 3: output register write/read, write to channel address ignored
      step(17, 32'h1234, 1, 0, 0);
      step(17, 0, 0, 1, 0);  chk("t3_q", 128'(q), 128'h1234);
      chk("t3_outslice", 128'(out_regs[63:32]), 128'h1234);
      step(1, 32'hFFFF_FFFF, 1, 0, 0);
      step(1, 0, 0, 1, 0);   chk("t3_ch0_ro", 128'(q), 128'd0);

      // 4: RAM ends and read-before-write
      step(64, 32'hA5, 1, 0, 0);
      step(127, 32'h5A, 1, 0, 0);
      step(64, 0, 0, 1, 0);  chk("t4_ram64", 128'(q), 128'hA5);
      step(127, 0, 0, 1, 0); chk("t4_ram127", 128'(q), 128'h5A);
      step(64, 32'hFF, 1, 1, 0); chk("t4_rbw", 128'(q), 128'hA5);
      step(64, 0, 0, 1, 0);  chk("t4_after", 128'(q), 128'hFF);

      // 5: strobe beats same-edge read-clear
      in_value[31:0] = 32'h11;
      step(0, 0, 0, 0, 5'b00001);
      in_value[31:0] = 32'h22;
      step(1, 0, 0, 1, 5'b00001);
      chk("t5_old", 128'(q), 128'h11);
      chk("t5_valid0", 128'(in_valid[0]), 128'd1);
      step(1, 0, 0, 1, 0);   chk("t5_new", 128'(q), 128'h22);

      // 6: double strobe on ch4, STATUS, W1C, async reset mid-sequence
      in_value[4*32 +: 32] = 32'h4444;
      step(0, 0, 0, 0, 5'b10000);
      step(0, 0, 0, 0, 5'b10000);
      step(15, 0, 0, 1, 0);
      chk("t6_status", 128'(q), OVR_EN ? 128'h0010_0010 : 128'h10);
      step(15, 32'h0010_0000, 1, 0, 0);
      step(0, 0, 0, 0, 5'b10000);
      step(18, 32'h77, 1, 0, 0);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      m_reset();
      chk("t6_rst_valid", 128'(in_valid), 128'd0);
      chk("t6_rst_q", 128'(q), 128'd0);
      chk("t6_rst_out", out_regs, 128'd0);
`ifdef MMIO_OVERRUN_EN
      chk("t6_rst_ovr", 128'(overrun), 128'd0);
`endif
      @(negedge clock);
      reset = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 5; i++) in_value[i*32 +: 32] = $urandom;
         ch_sel = $urandom_range(0, 9);
         case (ch_sel)
            0:       a_r = 0;
            1, 9:    a_r = $urandom_range(1, 5);
            2:       a_r = 15;
            3:       a_r = $urandom_range(16, 19);
            4, 5:    a_r = $urandom_range(64, 127);
            6:       a_r = 999;
            7:       a_r = $urandom_range(20, 63);
            default: a_r = $urandom_range(128, 200);
         endcase
         for (int i = 0; i < 5; i++) stb_r[i] = ($urandom_range(0, 3) == 0);
         step(a_r, $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), stb_r);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
